// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one block-RAM port between I-cache and D-cache,
// with a watchdog that aborts a RAM access that never returns ram_valid.
`timescale 1ns/1ps
module bram_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        cpu_clk,
  input  logic        rst,
  input  logic        ic_req,
  input  logic [31:0] ic_addr,
  input  logic        dc_req,
  input  logic        dc_we,
  input  logic [31:0] dc_addr,
  input  logic [31:0] dc_wdata,
  output logic        ic_ack,
  output logic        dc_ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy,
  output logic        ram_req,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic        ram_valid,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  state_t      r_state;
  state_t      w_next;
  logic        r_gnt_d;
  logic        r_last_d;
  logic        r_we;
  logic        r_err;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [7:0]  r_cnt;

  logic w_any_req;
  logic w_pick_d;
  logic w_timeout;

  assign w_any_req = ic_req | dc_req;
  // D wins when alone, or when both request and I was granted last.
  assign w_pick_d  = dc_req & (~ic_req | ~r_last_d);
  assign w_timeout = (r_cnt == TO_LIMIT);

  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    ram_req = 1'b0;
    busy    = 1'b1;
    ic_ack  = 1'b0;
    dc_ack  = 1'b0;
    err     = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_any_req) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        ram_req = 1'b1;
        w_next  = S_WAIT;
      end
      S_WAIT: begin
        if (ram_valid || w_timeout) w_next = S_RESP;
      end
      S_RESP: begin
        ic_ack = ~r_gnt_d;
        dc_ack = r_gnt_d;
        err    = r_err;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      r_gnt_d  <= 1'b0;
      r_last_d <= 1'b0;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_gnt_d <= w_pick_d;
            r_addr  <= w_pick_d ? dc_addr : ic_addr;
            r_we    <= w_pick_d & dc_we;
            r_wdata <= w_pick_d ? dc_wdata : 32'd0;
          end
        end
        S_ISSUE: begin
          r_cnt <= '0;
        end
        S_WAIT: begin
          // A late ram_valid still wins over a timeout in the same cycle.
          if (ram_valid) begin
            r_rdata <= r_we ? 32'd0 : ram_rdata;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_rdata <= 32'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_RESP: begin
          r_last_d <= r_gnt_d;
          r_err    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign ram_we    = r_we;
  assign ram_addr  = r_addr;
  assign ram_wdata = r_wdata;
  assign rdata     = r_rdata;

endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: cycle-stepped RAM model plus a transaction-level
// reference (round-robin winner, latency arithmetic) checked per transaction.
`timescale 1ns/1ps
module tb_bram_arbiter;

  localparam int TO = 15;

  logic        cpu_clk = 1'b0;
  logic        rst = 1'b1;
  logic        ic_req = 1'b0;
  logic [31:0] ic_addr = '0;
  logic        dc_req = 1'b0;
  logic        dc_we = 1'b0;
  logic [31:0] dc_addr = '0;
  logic [31:0] dc_wdata = '0;
  logic        ram_valid = 1'b0;
  logic [31:0] ram_rdata = '0;
  logic        ic_ack, dc_ack, err, busy, ram_req, ram_we;
  logic [31:0] rdata, ram_addr, ram_wdata;

  bram_arbiter #(.TIMEOUT(TO)) dut (
    .cpu_clk(cpu_clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .ic_ack(ic_ack), .dc_ack(dc_ack), .rdata(rdata), .err(err), .busy(busy),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_valid(ram_valid), .ram_rdata(ram_rdata)
  );

  always #5 cpu_clk = ~cpu_clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int lat = 9;        // ram_req-to-ram_valid distance; 0 = RAM never answers
  int ram_cd = 0;
  int nreq = 0;
  bit stray = 1'b0;
  bit stab_err = 1'b0;
  bit txn_open = 1'b0;
  bit model_last_d = 1'b0;
  logic [31:0] ram_data = '0;
  logic [31:0] cap_addr = '0;
  logic [31:0] cap_wdata = '0;
  logic        cap_we = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance one cycle; outputs are sampled 1ns after the edge, inputs driven then too.
  task automatic tick();
    @(posedge cpu_clk);
    #1;
    cyc++;
    ram_valid = 1'b0;
    ram_rdata = $urandom;
    if (rst) begin
      ram_cd   = 0;
      txn_open = 1'b0;
    end else if (ram_cd > 0) begin
      ram_cd--;
      if (ram_cd == 0) begin
        ram_valid = 1'b1;
        ram_rdata = ram_data;
      end
    end
    if (ram_req) begin
      nreq++;
      if (lat > 0) ram_cd = lat;
      cap_addr  = ram_addr;
      cap_we    = ram_we;
      cap_wdata = ram_wdata;
      txn_open  = 1'b1;
    end else if (txn_open && busy &&
                 (ram_addr !== cap_addr || ram_we !== cap_we || ram_wdata !== cap_wdata)) begin
      stab_err = 1'b1;
    end
    if (ic_ack || dc_ack) txn_open = 1'b0;
    if (stray && !ram_valid && (ram_req || ic_ack || dc_ack || !busy))
      ram_valid = 1'($urandom_range(0, 1));
  endtask

  // Current cycle is the IDLE cycle in which the requests are visible (cycle 0).
  // mode: 0 = winner drops req in ack cycle, 1 = both keep requesting, 2 = both drop.
  task automatic serve(input string tag, input int mode);
    int t0;
    int exp_off;
    int busy_low;
    bit win_d;
    bit seen;
    logic [31:0] exp_addr, exp_wd, exp_rd;
    logic exp_we, exp_err;
    t0       = cyc;
    win_d    = (ic_req && dc_req) ? !model_last_d : dc_req;
    exp_addr = win_d ? dc_addr : ic_addr;
    exp_we   = win_d ? dc_we : 1'b0;
    exp_wd   = win_d ? dc_wdata : 32'd0;
    exp_err  = (lat == 0) || (lat > TO + 1);
    exp_off  = exp_err ? TO + 3 : lat + 2;
    exp_rd   = (exp_err || exp_we) ? 32'd0 : ram_data;
    nreq = 0; stab_err = 1'b0; busy_low = 0; seen = 1'b0;
    while (!seen && (cyc - t0) < 60) begin
      tick();
      if (!busy) busy_low++;
      if (ic_ack || dc_ack) seen = 1'b1;
    end
    chk({tag, "_ack_cycle"}, 32'(cyc - t0), 32'(exp_off));
    chk({tag, "_ack_which"}, {30'd0, dc_ack, ic_ack}, win_d ? 32'd2 : 32'd1);
    chk({tag, "_rdata"}, rdata, exp_rd);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_ram_req_count"}, 32'(nreq), 32'd1);
    chk({tag, "_ram_addr"}, cap_addr, exp_addr);
    chk({tag, "_ram_we"}, cap_we, exp_we);
    chk({tag, "_ram_wdata"}, cap_wdata, exp_wd);
    chk({tag, "_stable"}, stab_err, 1'b0);
    chk({tag, "_busy_low"}, 32'(busy_low), 32'd0);
    model_last_d = win_d;
    if (mode == 2) begin
      ic_req = 1'b0; dc_req = 1'b0;
    end else if (mode == 0) begin
      if (win_d) dc_req = 1'b0; else ic_req = 1'b0;
    end
    tick();
    chk({tag, "_idle_after"}, {29'd0, busy, ic_ack, dc_ack}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    model_last_d = 1'b0;
  endtask

  initial begin
    int acks;
    int r;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_ctrl", {26'd0, ic_ack, dc_ack, err, busy, ram_req, ram_we}, 32'd0);
    chk("reset_ram_addr", ram_addr, 32'd0);
    chk("reset_ram_wdata", ram_wdata, 32'd0);
    chk("reset_rdata", rdata, 32'd0);

    // Plain I-cache read
    lat = 9; ram_data = 32'hDEADBEEF;
    ic_addr = 32'h100; ic_req = 1'b1;
    serve("ic_read", 0);

    // Contention from reset: D, I, D, I, acks 12 cycles apart
    do_reset();
    ic_addr = 32'h200; dc_addr = 32'h300; dc_wdata = 32'hAAAA5555;
    ic_req = 1'b1; dc_req = 1'b1;
    ram_data = 32'h11111111; serve("cont1_d", 1);
    ram_data = 32'h22222222; serve("cont2_i", 1);
    ram_data = 32'h33333333; serve("cont3_d", 1);
    ram_data = 32'h44444444; serve("cont4_i", 2);

    // D-cache write returns rdata 0
    dc_we = 1'b1; dc_addr = 32'h40; dc_wdata = 32'h12345678; dc_req = 1'b1;
    ram_data = 32'hCAFEF00D;
    serve("dc_write", 0);
    dc_we = 1'b0;

    // Watchdog abort, then ram_valid on the last legal WAIT cycle
    lat = 0; ic_addr = 32'h500; ic_req = 1'b1;
    serve("timeout", 0);
    lat = TO + 1; ram_data = 32'h0BADCAFE; ic_req = 1'b1;
    serve("late_valid", 0);

    // Reset in cycle 5 of an I-cache read
    lat = 9; ram_data = 32'h5A5A5A5A; ic_addr = 32'h600; ic_req = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    chk("midrst_ctrl", {26'd0, ic_ack, dc_ack, err, busy, ram_req, ram_we}, 32'd0);
    chk("midrst_ram_addr", ram_addr, 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    rst = 1'b0; ic_req = 1'b0; model_last_d = 1'b0;
    acks = 0;
    repeat (20) begin
      tick();
      if (ic_ack || dc_ack) acks++;
    end
    chk("midrst_no_ack", 32'(acks), 32'd0);
    ic_addr = 32'h700; ic_req = 1'b1;
    serve("post_rst", 0);

    // Randomized traffic with stray ram_valid pulses outside WAIT
    stray = 1'b1;
    for (int k = 0; k < 150; k++) begin
      if (!ic_req && !dc_req) repeat ($urandom_range(0, 3)) tick();
      r = $urandom_range(1, 3);
      if (r[0] && !ic_req) begin
        ic_req = 1'b1; ic_addr = $urandom;
      end
      if (r[1] && !dc_req) begin
        dc_req = 1'b1; dc_addr = $urandom; dc_we = 1'($urandom_range(0, 1)); dc_wdata = $urandom;
      end
      lat = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TO + 1);
      ram_data = $urandom;
      serve("rand", 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_arbiter.md
# bram_arbiter

Shares the single block-RAM port between the instruction cache and the data cache. Each request is turned into a one-cycle `ram_req` pulse toward the RAM model, which drives that model's `cache_ram_valid` input. The arbiter waits for `ram_valid` (the RAM model's `bram_valid`), captures the read data and returns a one-cycle acknowledge to the granted cache. It sits between the two cache controllers and the RAM model, and guards against a hung RAM with a watchdog timeout.

## Interface
- `TIMEOUT`, default 15: WAIT-state cycle budget before abort; range 1..255; counter width 8 bits.
- `cpu_clk`  in  1  clock; all logic on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `ic_req`  in  1  I-cache request; level, held until `ic_ack`
- `ic_addr`  in  32  I-cache read address
- `dc_req`  in  1  D-cache request; level, held until `dc_ack`
- `dc_we`  in  1  D-cache write enable (1 = write, 0 = read)
- `dc_addr`  in  32  D-cache address
- `dc_wdata`  in  32  D-cache write data
- `ic_ack`  out  1  one-cycle completion pulse to the I-cache
- `dc_ack`  out  1  one-cycle completion pulse to the D-cache
- `rdata`  out  32  read data; valid in the ack cycle
- `err`  out  1  timeout flag; asserted together with the ack of an aborted transaction
- `busy`  out  1  high in every state except IDLE
- `ram_req`  out  1  one-cycle start pulse to the RAM
- `ram_we`  out  1  write enable to the RAM
- `ram_addr`  out  32  address to the RAM
- `ram_wdata`  out  32  write data to the RAM
- `ram_valid`  in  1  RAM completion pulse
- `ram_rdata`  in  32  RAM read data; valid with `ram_valid`

## Operation
- **FSM states:** IDLE, ISSUE, WAIT, RESP. All outputs are registered or decoded from the state register; no input-to-output combinational paths.
- **IDLE**
  - If any request is high, latch the winner, its address, `we` and `wdata`, then go to ISSUE.
  - I-cache requests always latch `we = 0` and `wdata = 0`.
- **Arbitration (round-robin)**
  - A sole requester wins.
  - If both request, the one not in `last_grant` wins.
  - Reset value of `last_grant` is I, so the D-cache wins the first simultaneous request.
  - `last_grant` updates in RESP.
- **ISSUE:** `ram_req = 1` for exactly this cycle. `ram_addr`, `ram_we` and `ram_wdata` show the latched values and stay stable through WAIT. Go to WAIT and clear the watchdog counter to 0.
- **WAIT**
  - If `ram_valid` is high: capture `ram_rdata` into `rdata` (writes capture 0) and go to RESP.
  - Otherwise, if `counter == TIMEOUT`: set the error flag, force `rdata = 0`, go to RESP.
  - Otherwise: increment the counter.
  - `ram_valid` takes priority over timeout in the same cycle.
- **RESP:** Pulse the granted ack for one cycle, with `err` if flagged. Update `last_grant`, clear the error flag, go to IDLE. Requests are ignored in this state.
- **Request rules**
  - A requester may drop `req` in its ack cycle.
  - If `req` is still high in the following IDLE cycle, it is a new request.
  - `ram_req` is never asserted while a transaction is outstanding.
- **Stray `ram_valid`** in IDLE, ISSUE or RESP is ignored.
- **Reset values (also apply on reset mid-transaction):** state IDLE; all outputs 0 (`ram_addr`, `ram_wdata` and `rdata` = 0); counter 0; `last_grant` = I. No ack is produced for an aborted transaction. The RAM model shares `rst`, so no stale `ram_valid` follows a reset.

## Timing
- Let L be the number of cycles from `ram_req` to `ram_valid`. L = 9 for the current RAM model.
- Request first seen in cycle 0:
  - `ram_req` in cycle 1.
  - `ram_valid` in cycle 1+L.
  - ack in cycle L+2 (cycle 11 with the current model).
- Back-to-back throughput: one transaction per L+3 cycles (ack cycle, then IDLE, then ISSUE).
- Timeout path:
  - WAIT is entered in cycle 2 with counter 0.
  - Abort decision in cycle 2+TIMEOUT.
  - Ack with `err` in cycle 3+TIMEOUT (cycle 18 with the default).
- `busy` is high from cycle 1 through the ack cycle inclusive.

## Test plan
- **I-cache read:** `ic_req` with `ic_addr = 0x100` in cycle 0; RAM model (L = 9) returns `0xDEADBEEF`. Required: `ram_req` in cycle 1 with `ram_addr = 0x100`, `ram_we = 0`; `ic_ack = 1` and `rdata = 0xDEADBEEF` in cycle 11; `dc_ack = 0` throughout.
- **Simultaneous requests:** `ic_req` and `dc_req` both raised in cycle 0 after reset. Required: D-cache served first (`dc_ack` in cycle 11). The I-cache `ram_req` follows in cycle 13 and `ic_ack` in cycle 23.
- **Continuous contention:** both requests held high for 4 transactions. Required: grant order D, I, D, I; acks exactly 12 cycles apart.
- **D-cache write:** `dc_we = 1`, `dc_addr = 0x40`, `dc_wdata = 0x12345678`. Required: `ram_we = 1` and `ram_wdata = 0x12345678` stable from ISSUE through WAIT; `dc_ack` in cycle 11 with `rdata = 0`.
- **Timeout:** `ram_valid` tied low, `TIMEOUT = 15`, I-cache read in cycle 0. Required: `ic_ack = 1`, `err = 1`, `rdata = 0` in cycle 18; `busy` low in cycle 19. Repeat with `ram_valid` arriving in cycle 17: normal ack in cycle 18 with `err = 0`.
- **Reset mid-operation:** assert `rst` in cycle 5 of an I-cache read. Required: in the next cycle all outputs are 0 and state is IDLE, and no `ic_ack` is ever produced. A request issued after `rst` drops completes normally in L+2 cycles.
